// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcode map, control states and flag layout.
// The multiplier opcode is only honoured when ALU_MC_MUL_EN is defined.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_PASS_A = 4'h5,
        OP_PASS_B = 4'h6,
        OP_NEG_A = 4'h7,
        OP_NEG_B = 4'h8,
        OP_NOT_A = 4'h9,
        OP_NOT_B = 4'hA,
        OP_MUL   = 4'hB,
        OP_SHL   = 4'hC,
        OP_SHR   = 4'hD
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    function automatic logic [3:0] pack_flags(input logic n, input logic v,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between the register-file read stage and writeback.
interface alu_mc_if #(parameter int WIDTH = 8);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic [3:0]       op_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic [WIDTH-1:0] result_hi_o;
    logic [3:0]       flags_o;
    logic             invalid_o;

    modport master (
        output in_valid_i, a_i, b_i, op_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, result_hi_o, flags_o, invalid_o
    );

    modport slave (
        input  in_valid_i, a_i, b_i, op_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, result_hi_o, flags_o, invalid_o
    );
endinterface

// File: rtl/alu_mc_mul_seq.sv
// Sequential shift-add unsigned multiplier: bit 0 is consumed on the start edge,
// the remaining WIDTH-1 bits on the following edges, then done stays high until the next start.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic               busy_reg;
    logic               done_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else if (start) begin
            acc_reg    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_reg  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_reg <= {1'b0, b[WIDTH-1:1]};
            count_reg  <= CW'(1);
            busy_reg   <= 1'b1;
            done_reg   <= 1'b0;
        end else if (busy_reg) begin
            acc_reg    <= acc_reg + (mplier_reg[0] ? mcand_reg : '0);
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + CW'(1);
            if (count_reg == CW'(WIDTH-1)) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

    assign done    = done_reg;
    assign product = acc_reg;

endmodule

// File: rtl/alu_mc.sv
// Handshaked WIDTH-bit ALU with registered result/flags and a valid/ready port pair.
// Define ALU_MC_MUL_EN to build the multi-cycle multiplier behind opcode 0xB.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    alu_mc_if.slave  bus
);

    localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

    state_e           state_reg;
    state_e           state_next;
    state_e           accept_state;
    logic             accept;
    logic             load_alu;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;
    logic             alu_invalid;
    logic             c_bit;
    logic             v_bit;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;
    logic [WIDTH-1:0] result_reg;
    logic [3:0]       flags_reg;
    logic             invalid_reg;

    assign bus.in_ready_o = (state_reg == IDLE) || ((state_reg == DONE) && bus.out_ready_i);
    assign accept         = bus.in_valid_i && bus.in_ready_o;

    // Single-cycle datapath; the extended shifts expose the last bit shifted out.
    always_comb begin
        alu_result  = '0;
        c_bit       = 1'b0;
        v_bit       = 1'b0;
        alu_invalid = 1'b0;
        sum_ext     = {1'b0, bus.a_i} + {1'b0, bus.b_i};
        shl_ext     = {1'b0, bus.a_i} << bus.b_i;
        shr_ext     = {bus.a_i, 1'b0} >> bus.b_i;
        case (bus.op_i)
            OP_ADD: begin
                alu_result = sum_ext[WIDTH-1:0];
                c_bit      = sum_ext[WIDTH];
                v_bit      = (bus.a_i[WIDTH-1] == bus.b_i[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != bus.a_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = bus.a_i - bus.b_i;
                c_bit      = bus.a_i < bus.b_i;
                v_bit      = (bus.a_i[WIDTH-1] != bus.b_i[WIDTH-1]) &&
                             (alu_result[WIDTH-1] != bus.a_i[WIDTH-1]);
            end
            OP_AND:    alu_result = bus.a_i & bus.b_i;
            OP_OR:     alu_result = bus.a_i | bus.b_i;
            OP_XOR:    alu_result = bus.a_i ^ bus.b_i;
            OP_PASS_A: alu_result = bus.a_i;
            OP_PASS_B: alu_result = bus.b_i;
            OP_NEG_A: begin
                alu_result = '0 - bus.a_i;
                v_bit      = bus.a_i[WIDTH-1] && alu_result[WIDTH-1];
            end
            OP_NEG_B: begin
                alu_result = '0 - bus.b_i;
                v_bit      = bus.b_i[WIDTH-1] && alu_result[WIDTH-1];
            end
            OP_NOT_A:  alu_result = ~bus.a_i;
            OP_NOT_B:  alu_result = ~bus.b_i;
            OP_SHL: begin
                if (bus.b_i < SHIFT_LIMIT) begin
                    alu_result = shl_ext[WIDTH-1:0];
                    c_bit      = shl_ext[WIDTH];
                end
            end
            OP_SHR: begin
                if (bus.b_i < SHIFT_LIMIT) begin
                    alu_result = shr_ext[WIDTH:1];
                    c_bit      = shr_ext[0];
                end
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL:    alu_result = '0;
`endif
            default:   alu_invalid = 1'b1;
        endcase
        alu_flags = alu_invalid ? 4'b0000 :
                    pack_flags(alu_result[WIDTH-1], v_bit, c_bit, alu_result == '0);
    end

`ifdef ALU_MC_MUL_EN
    logic               is_mul;
    logic               mul_start;
    logic               mul_done;
    logic               load_mul;
    logic [2*WIDTH-1:0] mul_product;
    logic [3:0]         mul_flags;
    logic [WIDTH-1:0]   result_hi_reg;

    assign is_mul       = (bus.op_i == OP_MUL);
    assign mul_start    = accept && is_mul;
    assign load_alu     = accept && !is_mul;
    assign load_mul     = (state_reg == MUL) && mul_done;
    assign accept_state = is_mul ? MUL : DONE;
    assign mul_flags    = pack_flags(mul_product[WIDTH-1], 1'b0,
                                     |mul_product[2*WIDTH-1:WIDTH],
                                     mul_product[WIDTH-1:0] == '0);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .start   (mul_start),
        .a       (bus.a_i),
        .b       (bus.b_i),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_hi_reg <= '0;
        end else if (load_alu) begin
            result_hi_reg <= '0;
        end else if (load_mul) begin
            result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
        end
    end

    assign bus.result_hi_o = result_hi_reg;
`else
    assign load_alu        = accept;
    assign accept_state    = DONE;
    assign bus.result_hi_o = '0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = accept_state;
`ifdef ALU_MC_MUL_EN
            MUL:  if (mul_done) state_next = DONE;
`endif
            DONE: begin
                if (accept)               state_next = accept_state;
                else if (bus.out_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            flags_reg   <= '0;
            invalid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_alu) begin
                result_reg  <= alu_result;
                flags_reg   <= alu_flags;
                invalid_reg <= alu_invalid;
            end
`ifdef ALU_MC_MUL_EN
            else if (load_mul) begin
                result_reg  <= mul_product[WIDTH-1:0];
                flags_reg   <= mul_flags;
                invalid_reg <= 1'b0;
            end
`endif
        end
    end

    assign bus.out_valid_o = (state_reg == DONE);
    assign bus.result_o    = result_reg;
    assign bus.flags_o     = flags_reg;
    assign bus.invalid_o   = invalid_reg;

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It takes WIDTH-bit operands through a valid/ready input port and returns a registered result and flags through a valid/ready output port. It keeps the existing 0x0–0xA opcode map and adds shifts and an optional multi-cycle shift-add multiplier. It sits between the register-file read stage and the writeback stage of the datapath.

## Interface
- WIDTH, 8: operand/result width, ≥2, power of two
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous, active-low reset
- in_valid_i  in  1  operands/op presented
- in_ready_o  out  1  block can accept
- a_i  in  WIDTH  operand A
- b_i  in  WIDTH  operand B / shift amount
- op_i  in  4  operation code
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- result_o  out  WIDTH  result (low half for MUL)
- result_hi_o  out  WIDTH  MUL high half; 0 for other ops
- flags_o  out  4  {N,V,C,Z}
- invalid_o  out  1  unsupported opcode

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 A, 6 B, 7 −A, 8 −B, 9 ~A, A ~B, B MUL (unsigned), C SHL A by B, D SHR (logical) A by B. E, F are invalid.
- All arithmetic wraps modulo 2^WIDTH.
- Z: result_o==0. N: result_o[WIDTH-1].
- C by operation:
  - ADD: carry out.
  - SUB: borrow (A<B unsigned).
  - SHL/SHR: last bit shifted out; 0 when the amount is 0.
  - MUL: |result_hi_o.
  - All others: 0.
- V: signed overflow for ADD/SUB/−A/−B; 0 otherwise.
- Shift amount is b_i taken as an unsigned value. If b_i ≥ WIDTH: result 0, C 0.
- Invalid op: result_o=0, result_hi_o=0, flags_o=0, invalid_o=1. A response is still returned, so every accepted transaction gets exactly one response.
- Operands and op are captured on acceptance. Later input changes have no effect.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → MUL on accept of MUL.
  - MUL → DONE after WIDTH iterations.
  - DONE → IDLE on out_ready_i, or DONE → DONE/MUL if a new transaction is accepted in the same cycle.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i).
- out_valid_o = (state==DONE).

## Timing
- Reset values: in_ready_o=1 after release. out_valid_o, result_o, result_hi_o, flags_o, invalid_o all 0. State IDLE.
- Latency from accept edge to out_valid_o high: single-cycle ops 1 cycle; MUL WIDTH+1 cycles.
- Throughput: one single-cycle op per clock while out_ready_i is held high (back-to-back through DONE).
- While out_valid_o=1 and out_ready_i=0, all outputs are held stable and in_ready_o=0.
- Reset asserted mid-MUL or in DONE aborts the transaction immediately. Outputs return to reset values and no response is issued.
- Simultaneous out_ready_i and in_valid_i in DONE: the old result retires and the new transaction is accepted in the same edge.

## Configuration
- ALU_MC_MUL_EN defined: op B is the shift-add multiplier and the MUL state exists.
- ALU_MC_MUL_EN undefined: op B is invalid (1-cycle invalid response), result_hi_o is tied to 0, and no multiplier logic is built.

## Structure
- Shared package alu_pkg:
  - op_e enum with the opcode values above.
  - state_e {IDLE, MUL, DONE}.
  - Flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3.
- Sub-module alu_mul_seq: WIDTH-iteration shift-add unsigned multiplier.
  - Ports: start, done, 2×WIDTH product.
  - Instantiated only under ALU_MC_MUL_EN.

## Test plan
All with WIDTH=8.
- ADD a=0xF0 b=0x20 → result 0x10, C=1, V=0, Z=0; out_valid_o 1 cycle after accept.
- SUB a=0x80 b=0x01 → 0x7F, V=1, C=0, N=0; SHL a=0x81 b=1 → 0x02, C=1; SHR a=0x01 b=9 → 0x00, Z=1, C=0.
- MUL a=0xFF b=0xFF (macro on) → result_hi_o=0xFE, result_o=0x01, C=1; out_valid_o exactly 9 cycles after accept, in_ready_o=0 throughout. With the macro off → invalid_o=1, result 0.
- Backpressure: hold out_ready_i=0 for 5 cycles after an XOR 0x5A^0xFF → 0xA5 held stable, in_ready_o=0, a concurrent in_valid_i is not accepted. Release: a back-to-back op is accepted on the retire edge.
- op=0xF → result 0, flags 0, invalid_o=1, latency 1; the following valid op clears invalid_o.
- rst_ni low during MUL cycle 4 → all outputs 0 immediately. After release in_ready_o=1 and no stale response appears.
